// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared phase codes, lamp bit positions and duration clamp for the traffic sequencer.
package traffic_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        FLASH  = 2'd3
    } phase_e;

    localparam int LAMP_G = 2;
    localparam int LAMP_Y = 1;
    localparam int LAMP_R = 0;

    function automatic int unsigned clamp(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control/config inputs and lamp/display outputs of the traffic sequencer.
interface traffic_phase_ctrl_if #(
    parameter int NUM_DIR = 2,
    parameter int CNT_W   = 7
);
    import traffic_pkg::*;
    localparam int DIR_W = $clog2(NUM_DIR);

    logic                     run;
    logic                     manual_step;
    logic                     load;
    logic [NUM_DIR*CNT_W-1:0] green_sec;
    logic [CNT_W-1:0]         yellow_sec;
    logic [CNT_W-1:0]         clear_sec;
    logic [NUM_DIR-1:0]       ped_req;
    logic                     flash;
    logic [3*NUM_DIR-1:0]     lights;
    logic [DIR_W-1:0]         active_dir;
    phase_e                   phase;
    logic [CNT_W-1:0]         count;
    logic                     count_valid;

    modport master (
        output run, manual_step, load, green_sec, yellow_sec, clear_sec, ped_req, flash,
        input  lights, active_dir, phase, count, count_valid
    );

    modport slave (
        input  run, manual_step, load, green_sec, yellow_sec, clear_sec, ped_req, flash,
        output lights, active_dir, phase, count, count_valid
    );

endinterface

// File: rtl/traffic_phase_ctrl_cfg_regs.sv
// Clamped shadow copy of the phase durations; returns the duration of a requested phase.
module traffic_cfg_regs
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int CNT_W      = 7,
    parameter int DIR_W      = 1,
    parameter int MAX_GREEN  = 99,
    parameter int MAX_YELLOW = 4,
    parameter int MAX_CLEAR  = 3
) (
    input  logic                           clk_out,
    input  logic                           reset,
    input  logic                           load,
    input  logic [NUM_DIR-1:0][CNT_W-1:0]  green_sec,
    input  logic [CNT_W-1:0]               yellow_sec,
    input  logic [CNT_W-1:0]               clear_sec,
    input  phase_e                         req_phase,
    input  logic [DIR_W-1:0]               req_dir,
    output logic [CNT_W-1:0]               dur
);

    logic [NUM_DIR-1:0][CNT_W-1:0] green_q;
    logic [CNT_W-1:0]              yellow_q;
    logic [CNT_W-1:0]              clear_q;

    always_ff @(posedge clk_out) begin
        if (reset) begin
            for (int d = 0; d < NUM_DIR; d++) green_q[d] <= CNT_W'(MAX_GREEN);
            yellow_q <= CNT_W'(MAX_YELLOW);
            clear_q  <= CNT_W'(MAX_CLEAR);
        end else if (load) begin
            for (int d = 0; d < NUM_DIR; d++)
                green_q[d] <= CNT_W'(clamp(32'(green_sec[d]), MAX_GREEN));
            yellow_q <= CNT_W'(clamp(32'(yellow_sec), MAX_YELLOW));
            clear_q  <= CNT_W'(clamp(32'(clear_sec), MAX_CLEAR));
        end
    end

    always_comb begin
        case (req_phase)
            GREEN:   dur = green_q[req_dir];
            YELLOW:  dur = yellow_q;
            default: dur = clear_q;
        endcase
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic sequencer: GREEN(a) -> YELLOW(a) -> CLEAR -> GREEN(a+1),
// with load clamping, pedestrian truncation, manual stepping and night flash.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int CNT_W      = 7,
    parameter int MAX_GREEN  = 99,
    parameter int MAX_YELLOW = 4,
    parameter int MAX_CLEAR  = 3,
    parameter int PED_CUT    = 5
) (
    input logic                 clk_out,
    input logic                 reset,
    traffic_phase_ctrl_if.slave bus
);

    localparam int DIR_W = $clog2(NUM_DIR);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t       PED_CUT_C = cnt_t'(PED_CUT);
    localparam logic [2:0] L_G = 3'(1 << LAMP_G);
    localparam logic [2:0] L_Y = 3'(1 << LAMP_Y);
    localparam logic [2:0] L_R = 3'(1 << LAMP_R);

    phase_e ph_q, ph_n, tgt_ph;
    logic [DIR_W-1:0] dir_q, dir_n, tgt_dir, dir_inc;
    cnt_t cnt_q, cnt_n, tgt_dur, cur_new;
    logic [NUM_DIR-1:0] pend_q, pend_n, eff_pend, act_mask, tgt_mask;
    logic trunc_q, trunc_n, fon_q, fon_n, cv_q, cv_n, step_q;
    logic step_edge, other_pend, go;
    logic [NUM_DIR-1:0][CNT_W-1:0] green_arr;
    logic [NUM_DIR-1:0][2:0]       lamp;

    assign green_arr  = bus.green_sec;
    assign step_edge  = bus.manual_step & ~step_q;
    assign dir_inc    = (dir_q == DIR_W'(NUM_DIR-1)) ? '0 : dir_q + 1'b1;
    assign act_mask   = NUM_DIR'(1) << dir_q;
    assign tgt_mask   = NUM_DIR'(1) << tgt_dir;
    assign eff_pend   = pend_q | bus.ped_req;
    assign other_pend = |(eff_pend & ~act_mask);

    // Successor of the current phase; leaving FLASH always lands in CLEAR.
    always_comb begin
        tgt_ph  = CLEAR;
        tgt_dir = dir_q;
        case (ph_q)
            CLEAR:   begin tgt_ph = GREEN; tgt_dir = dir_inc; end
            GREEN:   tgt_ph = YELLOW;
            default: tgt_ph = CLEAR;
        endcase
    end

    traffic_cfg_regs #(
        .NUM_DIR(NUM_DIR), .CNT_W(CNT_W), .DIR_W(DIR_W),
        .MAX_GREEN(MAX_GREEN), .MAX_YELLOW(MAX_YELLOW), .MAX_CLEAR(MAX_CLEAR)
    ) u_cfg (
        .clk_out   (clk_out),
        .reset     (reset),
        .load      (bus.load),
        .green_sec (green_arr),
        .yellow_sec(bus.yellow_sec),
        .clear_sec (bus.clear_sec),
        .req_phase (tgt_ph),
        .req_dir   (tgt_dir),
        .dur       (tgt_dur)
    );

    // Clamped value being loaded this tick for the phase currently running.
    always_comb begin
        case (ph_q)
            GREEN:   cur_new = CNT_W'(clamp(32'(green_arr[dir_q]), MAX_GREEN));
            YELLOW:  cur_new = CNT_W'(clamp(32'(bus.yellow_sec), MAX_YELLOW));
            default: cur_new = CNT_W'(clamp(32'(bus.clear_sec), MAX_CLEAR));
        endcase
    end

    always_comb begin
        ph_n    = ph_q;
        dir_n   = dir_q;
        cnt_n   = cnt_q;
        trunc_n = trunc_q;
        fon_n   = 1'b1;
        cv_n    = bus.run;
        pend_n  = eff_pend;
        go      = 1'b0;
        if (bus.flash) begin
            ph_n  = FLASH;
            cnt_n = '0;
            cv_n  = 1'b0;
            fon_n = (ph_q == FLASH) ? ~fon_q : 1'b1;
        end else if (ph_q == FLASH) begin
            go = 1'b1;
        end else if (!bus.run) begin
            go = step_edge;
        end else if (bus.load && cnt_q > cur_new) begin
            cnt_n = cur_new;
        end else if (ph_q == GREEN && !trunc_q && other_pend && cnt_q > PED_CUT_C) begin
            cnt_n   = PED_CUT_C;
            trunc_n = 1'b1;
        end else if (cnt_q == '0) begin
            go = 1'b1;
        end else begin
            cnt_n = cnt_q - 1'b1;
        end
        if (go) begin
            ph_n  = tgt_ph;
            dir_n = tgt_dir;
            cnt_n = tgt_dur;
            if (tgt_ph == GREEN) begin
                trunc_n = 1'b0;
                pend_n  = (pend_q & ~tgt_mask) | bus.ped_req;
            end
        end
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            ph_q    <= CLEAR;
            dir_q   <= DIR_W'(NUM_DIR-1);
            cnt_q   <= '0;
            pend_q  <= '0;
            trunc_q <= 1'b0;
            fon_q   <= 1'b0;
            cv_q    <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            ph_q    <= ph_n;
            dir_q   <= dir_n;
            cnt_q   <= cnt_n;
            pend_q  <= pend_n;
            trunc_q <= trunc_n;
            fon_q   <= fon_n;
            cv_q    <= cv_n;
            step_q  <= bus.manual_step;
        end
    end

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_lamp
        logic own;
        assign own     = (dir_q == DIR_W'(d));
        assign lamp[d] = (ph_q == FLASH)          ? (fon_q ? L_Y : 3'b000) :
                         (own && ph_q == GREEN)   ? L_G :
                         (own && ph_q == YELLOW)  ? L_Y : L_R;
    end

    assign bus.lights      = lamp;
    assign bus.active_dir  = dir_q;
    assign bus.phase       = ph_q;
    assign bus.count       = cnt_q;
    assign bus.count_valid = cv_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed-vector bench for traffic_phase_ctrl with NUM_DIR=2, CNT_W=8.
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;

    logic clk_out = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_out = ~clk_out;

    traffic_phase_ctrl_if #(.NUM_DIR(2), .CNT_W(8)) bus ();

    traffic_phase_ctrl #(.NUM_DIR(2), .CNT_W(8)) dut (
        .clk_out(clk_out),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    function automatic logic [5:0] exp_lights(input logic [1:0] ph, input int dir, input logic fon);
        logic [5:0] l;
        l = 6'b001_001;
        case (ph)
            GREEN:   l[3*dir +: 3] = 3'b100;
            YELLOW:  l[3*dir +: 3] = 3'b010;
            FLASH:   l = fon ? 6'b010_010 : 6'b000_000;
            default: l = 6'b001_001;
        endcase
        return l;
    endfunction

    task automatic chk_st(input string tag, input logic [1:0] ph, input int dir,
                          input int cnt, input logic cv, input logic fon);
        int nonr;
        chk($sformatf("%s_phase", tag), bus.phase, ph);
        chk($sformatf("%s_dir", tag), bus.active_dir, dir);
        chk($sformatf("%s_count", tag), bus.count, cnt);
        chk($sformatf("%s_cv", tag), bus.count_valid, cv);
        chk($sformatf("%s_lights", tag), bus.lights, exp_lights(ph, dir, fon));
        if (ph != FLASH) begin
            nonr = 0;
            for (int d = 0; d < 2; d++) if (bus.lights[3*d +: 3] != 3'b001) nonr++;
            chk($sformatf("%s_excl", tag), nonr <= 1, 1);
        end
    endtask

    // Checks every tick of a phase from count n down to 0, ending in the next phase.
    task automatic run_phase(input string tag, input logic [1:0] ph, input int dir, input int n);
        for (int i = n; i >= 0; i--) begin
            chk_st($sformatf("%s_%0d", tag, i), ph, dir, i, 1'b1, 1'b0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.run = 1'b1; bus.manual_step = 1'b0; bus.load = 1'b0;
        bus.flash = 1'b0; bus.ped_req = 2'b00;
        bus.green_sec = {8'd6, 8'd10}; bus.yellow_sec = 8'd3; bus.clear_sec = 8'd1;
        tick(); tick();
        chk_st("rst", CLEAR, 1, 0, 1'b0, 1'b0);

        reset = 1'b0; bus.run = 1'b0; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_st("cfg", CLEAR, 1, 0, 1'b0, 1'b0);
        bus.run = 1'b1;
        tick();
        run_phase("g0", GREEN, 0, 10);
        run_phase("y0", YELLOW, 0, 3);
        run_phase("c0", CLEAR, 0, 1);
        run_phase("g1", GREEN, 1, 6);
        run_phase("y1", YELLOW, 1, 3);
        run_phase("c1", CLEAR, 1, 1);

        // pedestrian truncation
        chk_st("ped_g0", GREEN, 0, 10, 1'b1, 1'b0);
        tick();
        chk_st("ped_9", GREEN, 0, 9, 1'b1, 1'b0);
        bus.ped_req = 2'b10; tick(); bus.ped_req = 2'b00;
        chk_st("ped_cut", GREEN, 0, 5, 1'b1, 1'b0);
        tick();
        chk_st("ped_4", GREEN, 0, 4, 1'b1, 1'b0);
        bus.ped_req = 2'b10; tick(); bus.ped_req = 2'b00;
        chk_st("ped_once", GREEN, 0, 3, 1'b1, 1'b0);
        run_phase("pg0", GREEN, 0, 3);
        run_phase("py0", YELLOW, 0, 3);
        run_phase("pc0", CLEAR, 0, 1);
        run_phase("pg1", GREEN, 1, 6);
        run_phase("py1", YELLOW, 1, 3);
        run_phase("pc1", CLEAR, 1, 1);
        chk_st("pend_g0", GREEN, 0, 10, 1'b1, 1'b0);
        tick();
        chk_st("pend_clr", GREEN, 0, 9, 1'b1, 1'b0);

        // load with run=1
        bus.green_sec = {8'd6, 8'd50}; bus.load = 1'b1; tick(); bus.load = 1'b0;
        chk_st("ld50", GREEN, 0, 8, 1'b1, 1'b0);
        run_phase("lg0", GREEN, 0, 8);
        run_phase("ly0", YELLOW, 0, 3);
        run_phase("lc0", CLEAR, 0, 1);
        run_phase("lg1", GREEN, 1, 6);
        run_phase("ly1", YELLOW, 1, 3);
        run_phase("lc1", CLEAR, 1, 1);
        chk_st("g50", GREEN, 0, 50, 1'b1, 1'b0);
        repeat (10) tick();
        chk_st("g40", GREEN, 0, 40, 1'b1, 1'b0);
        bus.green_sec = {8'd6, 8'd20}; bus.load = 1'b1; tick(); bus.load = 1'b0;
        chk_st("ld20", GREEN, 0, 20, 1'b1, 1'b0);
        bus.green_sec = {8'd6, 8'd150}; bus.yellow_sec = 8'd9;
        bus.load = 1'b1; tick(); bus.load = 1'b0;
        chk_st("ld150", GREEN, 0, 19, 1'b1, 1'b0);
        run_phase("mg0", GREEN, 0, 19);
        run_phase("my0", YELLOW, 0, 4);
        run_phase("mc0", CLEAR, 0, 1);
        run_phase("mg1", GREEN, 1, 6);
        run_phase("my1", YELLOW, 1, 4);
        run_phase("mc1", CLEAR, 1, 1);
        chk_st("gmax", GREEN, 0, 99, 1'b1, 1'b0);
        bus.green_sec = {8'd6, 8'd5}; bus.load = 1'b1; tick(); bus.load = 1'b0;
        chk_st("ld5", GREEN, 0, 5, 1'b1, 1'b0);
        run_phase("sg0", GREEN, 0, 5);
        tick(); tick();
        chk_st("y0_2", YELLOW, 0, 2, 1'b1, 1'b0);

        // frozen and manual stepping
        bus.run = 1'b0; tick();
        chk_st("hold_a", YELLOW, 0, 2, 1'b0, 1'b0);
        tick();
        chk_st("hold_b", YELLOW, 0, 2, 1'b0, 1'b0);
        bus.manual_step = 1'b1; tick();
        chk_st("step_clr", CLEAR, 0, 1, 1'b0, 1'b0);
        tick();
        chk_st("step_lvl", CLEAR, 0, 1, 1'b0, 1'b0);
        bus.manual_step = 1'b0; tick();
        bus.manual_step = 1'b1; tick();
        chk_st("step_g1", GREEN, 1, 6, 1'b0, 1'b0);
        bus.manual_step = 1'b0; tick();
        chk_st("hold_g1", GREEN, 1, 6, 1'b0, 1'b0);
        bus.manual_step = 1'b1; tick(); bus.manual_step = 1'b0;
        chk_st("step_y1", YELLOW, 1, 4, 1'b0, 1'b0);

        // night flash
        bus.run = 1'b1; tick();
        chk_st("resume", YELLOW, 1, 3, 1'b1, 1'b0);
        run_phase("fy1", YELLOW, 1, 3);
        run_phase("fc1", CLEAR, 1, 1);
        run_phase("fg0", GREEN, 0, 5);
        run_phase("fy0", YELLOW, 0, 4);
        run_phase("fc0", CLEAR, 0, 1);
        tick();
        chk_st("g1_5", GREEN, 1, 5, 1'b1, 1'b0);
        bus.flash = 1'b1; tick();
        chk_st("fl_on1", FLASH, 1, 0, 1'b0, 1'b1);
        tick();
        chk_st("fl_off", FLASH, 1, 0, 1'b0, 1'b0);
        tick();
        chk_st("fl_on2", FLASH, 1, 0, 1'b0, 1'b1);
        bus.flash = 1'b0; tick();
        run_phase("fx", CLEAR, 1, 1);
        chk_st("fx_g0", GREEN, 0, 5, 1'b1, 1'b0);

        // reset mid yellow
        run_phase("rg0", GREEN, 0, 5);
        tick();
        chk_st("ry0", YELLOW, 0, 3, 1'b1, 1'b0);
        reset = 1'b1; tick();
        chk_st("rst2", CLEAR, 1, 0, 1'b0, 1'b0);
        reset = 1'b0; tick();
        chk_st("rel_g0", GREEN, 0, 99, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
